// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a PC through instruction memory from a start pulse
// until a halt opcode, handling stalls, redirects and a saturating issue counter.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic [5:0]  imem_control,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic        busy,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] count_q, count_d;

    logic        is_halt_op;
    logic        issue;
    logic [31:0] redirect_target;

    // Targets are word aligned; the low byte-offset bits are intentionally dropped.
    logic        unused_redirect_low;
    assign unused_redirect_low = ^redirect_addr[1:0];

    assign is_halt_op      = (imem_control == HALT_OP);
    assign redirect_target = {redirect_addr[31:2], 2'b00};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        issue   = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                    count_d = '0;
                end
            end

            S_RUN: begin
                issue = !stall && !is_halt_op;

                // Redirect wins over both stall and halt detection.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (issue) begin
                    pc_d = pc_q + 32'd4;
                end else if (!stall) begin
                    state_d = S_HALT;
                end

                if (issue && (count_q != COUNT_MAX)) begin
                    count_d = count_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from the values present before the edge.
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = issue;
    assign busy        = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;

endmodule
